// File: rtl/ni_packetizer.sv
// ni_packetizer
//   Network-interface transmit side. Each local message (destination, length,
//   then `length` payload words) is turned into a head flit followed by body
//   flits, the last of which is marked as tail. A zero-length message becomes
//   a single head-only flit. The output is a registered valid/ready stream
//   that plugs straight into a router ingress port, and it sustains one flit
//   per cycle.
//
// Handshake rule (applies to msg_*, pld_* and flt_*): a transfer happens on a
// rising edge where valid and ready are both 1. A producer holding valid=1
// keeps its data stable until the transfer. Ready may depend combinationally
// on the downstream ready. Valid never depends on ready.
//
// Ports
//   clk        clock, rising edge
//   srst       synchronous reset, active low
//   msg_val    message header valid         msg_rdy  header accepted
//   msg_dst    destination node ID (4b)     msg_len  payload word count (8b)
//   pld_val    payload word valid           pld_rdy  payload word accepted
//   pld_dat    payload word (PORT_WIDTH-2)
//   flt_val    flit valid to router         flt_rdy  router ready
//   flt_dat    flit (PORT_WIDTH)
//   dbg_state  current FSM state (0 = IDLE, 1 = BODY)
//
// Flit layout (W = PORT_WIDTH)
//   [W-1:W-2] type: 01 head, 00 body, 10 tail, 11 head-only
//   head : [W-3:W-6] dst, [W-7:W-10] NODE_ID, [W-11:W-18] len,
//          [W-19:W-26] seq; all other bits 0
//   body : [W-3:0] payload word
module ni_packetizer #(
  parameter int PORT_WIDTH = 128,
  parameter int NODE_ID    = 0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  msg_val,
  output logic                  msg_rdy,
  input  logic [3:0]            msg_dst,
  input  logic [7:0]            msg_len,
  input  logic                  pld_val,
  output logic                  pld_rdy,
  input  logic [PORT_WIDTH-3:0] pld_dat,
  output logic                  flt_val,
  input  logic                  flt_rdy,
  output logic [PORT_WIDTH-1:0] flt_dat,
  output logic                  dbg_state
);

  localparam int W = PORT_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t       state;
  logic [7:0]   rem;   // payload words still to be accepted in this packet
  logic [7:0]   seq;   // per-message sequence number, stamped into heads

  logic         slot_free;
  logic         msg_hs;
  logic         pld_hs;
  logic [W-1:0] head_flit;

  // The output register can take a new flit when it is empty or when its
  // current flit is leaving on this edge.
  assign slot_free = !flt_val || flt_rdy;

  // Gating with srst keeps both readies low during reset, so inputs on a
  // reset cycle never complete a handshake.
  assign msg_rdy = srst && (state == IDLE) && slot_free;
  assign pld_rdy = srst && (state == BODY) && slot_free;

  assign msg_hs = msg_val && msg_rdy;
  assign pld_hs = pld_val && pld_rdy;

  assign dbg_state = (state == BODY);

  always_comb begin
    head_flit              = '0;
    head_flit[W-1:W-2]     = (msg_len == 8'd0) ? 2'b11 : 2'b01;
    head_flit[W-3:W-6]     = msg_dst;
    head_flit[W-7:W-10]    = 4'(NODE_ID);
    head_flit[W-11:W-18]   = msg_len;
    head_flit[W-19:W-26]   = seq;
  end

  always_ff @(posedge clk) begin
    if (!srst) begin
      state   <= IDLE;
      rem     <= '0;
      seq     <= '0;
      flt_val <= 1'b0;
      flt_dat <= '0;
    end else begin
      if (msg_hs) begin
        flt_val <= 1'b1;
        flt_dat <= head_flit;
        seq     <= seq + 8'd1;
        if (msg_len != 8'd0) begin
          rem   <= msg_len;
          state <= BODY;
        end
      end else if (pld_hs) begin
        flt_val <= 1'b1;
        // rem==1 means this word is the last one of the packet.
        flt_dat <= {(rem == 8'd1) ? 2'b10 : 2'b00, pld_dat};
        rem     <= rem - 8'd1;
        if (rem == 8'd1) begin
          state <= IDLE;
        end
      end else if (slot_free) begin
        // Flit consumed (or none present) and nothing new: empty the slot.
        // flt_dat keeps its last value; only flt_val is meaningful.
        flt_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer
//   Directed bench for ni_packetizer. Each vector applies one cycle of inputs,
//   checks the combinational readies before the edge, then checks the
//   registered flit output just after the edge.
module tb_ni_packetizer;

  localparam int         W    = 128;
  localparam int         P    = W - 2;
  localparam logic [3:0] NODE = 4'd9;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         srst;
  logic         msg_val;
  logic         msg_rdy;
  logic [3:0]   msg_dst;
  logic [7:0]   msg_len;
  logic         pld_val;
  logic         pld_rdy;
  logic [P-1:0] pld_dat;
  logic         flt_val;
  logic         flt_rdy;
  logic [W-1:0] flt_dat;
  logic         dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ni_packetizer #(.PORT_WIDTH(W), .NODE_ID(int'(NODE))) dut (
    .clk       (clk),
    .srst      (srst),
    .msg_val   (msg_val),
    .msg_rdy   (msg_rdy),
    .msg_dst   (msg_dst),
    .msg_len   (msg_len),
    .pld_val   (pld_val),
    .pld_rdy   (pld_rdy),
    .pld_dat   (pld_dat),
    .flt_val   (flt_val),
    .flt_rdy   (flt_rdy),
    .flt_dat   (flt_dat),
    .dbg_state (dbg_state)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic         rst_n;
    logic         mv;
    logic [3:0]   dst;
    logic [7:0]   len;
    logic         pv;
    logic [P-1:0] pdat;
    logic         frdy;
    logic         e_mrdy;
    logic         e_prdy;
    logic         e_fval;
    logic         chk_dat;
    logic [W-1:0] e_dat;
  } vec_t;

  vec_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  function automatic vec_t vec(input logic rst_n, input logic mv, input logic [3:0] dst,
                               input logic [7:0] len, input logic pv, input logic [P-1:0] pdat,
                               input logic frdy, input logic e_mrdy, input logic e_prdy,
                               input logic e_fval, input logic chk_dat, input logic [W-1:0] e_dat);
    vec_t v;
    v.rst_n = rst_n; v.mv = mv; v.dst = dst; v.len = len; v.pv = pv; v.pdat = pdat;
    v.frdy = frdy; v.e_mrdy = e_mrdy; v.e_prdy = e_prdy; v.e_fval = e_fval;
    v.chk_dat = chk_dat; v.e_dat = e_dat;
    return v;
  endfunction

  function automatic logic [W-1:0] mk_head(input logic [1:0] t, input logic [3:0] dst,
                                           input logic [7:0] len, input logic [7:0] s);
    logic [W-1:0] h;
    h            = '0;
    h[W-1:W-2]   = t;
    h[W-3:W-6]   = dst;
    h[W-7:W-10]  = NODE;
    h[W-11:W-18] = len;
    h[W-19:W-26] = s;
    return h;
  endfunction

  function automatic logic [W-1:0] mk_body(input logic [1:0] t, input logic [P-1:0] d);
    return {t, d};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input string nm);
    srst    = v.rst_n;
    msg_val = v.mv;
    msg_dst = v.dst;
    msg_len = v.len;
    pld_val = v.pv;
    pld_dat = v.pdat;
    flt_rdy = v.frdy;
    #1;
    check({nm, ".msg_rdy"}, W'(msg_rdy), W'(v.e_mrdy));
    check({nm, ".pld_rdy"}, W'(pld_rdy), W'(v.e_prdy));
    @(posedge clk);
    #1;
    check({nm, ".flt_val"}, W'(flt_val), W'(v.e_fval));
    if (v.chk_dat) check({nm, ".flt_dat"}, flt_dat, v.e_dat);
  endtask

  localparam logic [P-1:0] PA = 126'h0AAA_0000_1111;
  localparam logic [P-1:0] PB = 126'h0BBB_2222_3333;
  localparam logic [P-1:0] PC = 126'h0CCC_4444_5555;
  localparam logic [P-1:0] PD = 126'h3DDD_6666_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [P-1:0] PX = 126'h1234_5678;

  initial begin
    srst = 1'b0; msg_val = 1'b0; msg_dst = '0; msg_len = '0;
    pld_val = 1'b0; pld_dat = '0; flt_rdy = 1'b1;

    // Reset with busy inputs (ignored), then head-only, idle, pld in IDLE,
    // a 3-word packet with msg_val held high in BODY, a 1-word packet
    // accepted the cycle after a tail, a 3-word packet with a 3-cycle stall
    // on B, and a stall on a head-only flit in IDLE.
    tbl.push_back(vec(0,1,4'd3,8'd0,1,PX,1, 0,0,0,1,'0));
    tbl.push_back(vec(0,0,4'd0,8'd0,0,PX,1, 0,0,0,1,'0));
    tbl.push_back(vec(1,1,4'd3,8'd0,0,PX,1, 1,0,1,1,mk_head(2'b11,4'd3,8'd0,8'd0)));
    tbl.push_back(vec(1,0,4'd0,8'd0,0,PX,1, 1,0,0,0,'0));
    tbl.push_back(vec(1,0,4'd0,8'd0,1,PX,1, 1,0,0,0,'0));
    tbl.push_back(vec(1,1,4'd5,8'd3,0,PX,1, 1,0,1,1,mk_head(2'b01,4'd5,8'd3,8'd1)));
    tbl.push_back(vec(1,1,4'd5,8'd3,1,PA,1, 0,1,1,1,mk_body(2'b00,PA)));
    tbl.push_back(vec(1,1,4'd5,8'd3,1,PB,1, 0,1,1,1,mk_body(2'b00,PB)));
    tbl.push_back(vec(1,1,4'd5,8'd3,1,PC,1, 0,1,1,1,mk_body(2'b10,PC)));
    tbl.push_back(vec(1,1,4'd7,8'd1,1,PX,1, 1,0,1,1,mk_head(2'b01,4'd7,8'd1,8'd2)));
    tbl.push_back(vec(1,0,4'd0,8'd0,1,PD,1, 0,1,1,1,mk_body(2'b10,PD)));
    tbl.push_back(vec(1,1,4'd5,8'd3,0,PX,1, 1,0,1,1,mk_head(2'b01,4'd5,8'd3,8'd3)));
    tbl.push_back(vec(1,0,4'd0,8'd0,1,PA,1, 0,1,1,1,mk_body(2'b00,PA)));
    tbl.push_back(vec(1,0,4'd0,8'd0,1,PB,1, 0,1,1,1,mk_body(2'b00,PB)));
    tbl.push_back(vec(1,0,4'd0,8'd0,1,PC,0, 0,0,1,1,mk_body(2'b00,PB)));
    tbl.push_back(vec(1,0,4'd0,8'd0,1,PC,0, 0,0,1,1,mk_body(2'b00,PB)));
    tbl.push_back(vec(1,0,4'd0,8'd0,1,PC,0, 0,0,1,1,mk_body(2'b00,PB)));
    tbl.push_back(vec(1,0,4'd0,8'd0,1,PC,1, 0,1,1,1,mk_body(2'b10,PC)));
    tbl.push_back(vec(1,0,4'd0,8'd0,0,PX,1, 1,0,0,0,'0));
    tbl.push_back(vec(1,1,4'd2,8'd0,0,PX,0, 1,0,1,1,mk_head(2'b11,4'd2,8'd0,8'd4)));
    tbl.push_back(vec(1,1,4'd9,8'd0,0,PX,0, 0,0,1,1,mk_head(2'b11,4'd2,8'd0,8'd4)));
    tbl.push_back(vec(1,1,4'd9,8'd0,0,PX,1, 1,0,1,1,mk_head(2'b11,4'd9,8'd0,8'd5)));
    tbl.push_back(vec(1,0,4'd0,8'd0,0,PX,1, 1,0,0,0,'0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // seq wrap: 257 head-only messages from a fresh reset.
    run_vec(vec(0,0,4'd0,8'd0,0,PX,1, 0,0,0,1,'0), "wrap_rst");
    for (int i = 0; i < 257; i++) exp_q.push_back(mk_head(2'b11, 4'(i), 8'd0, 8'(i)));
    for (int i = 0; i < 257; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      run_vec(vec(1,1,4'(i),8'd0,0,PX,1, 1,0,1,1,e), $sformatf("wrap%0d", i));
    end

    // Mid-packet reset after the 2nd of 4 body flits, then a fresh message.
    run_vec(vec(1,1,4'd1,8'd4,0,PX,1, 1,0,1,1,mk_head(2'b01,4'd1,8'd4,8'd1)), "mr_head");
    run_vec(vec(1,0,4'd0,8'd0,1,PA,1, 0,1,1,1,mk_body(2'b00,PA)), "mr_b1");
    run_vec(vec(1,0,4'd0,8'd0,1,PB,1, 0,1,1,1,mk_body(2'b00,PB)), "mr_b2");
    run_vec(vec(0,1,4'd6,8'd0,1,PC,1, 0,0,0,1,'0), "mr_rst");
    run_vec(vec(1,1,4'd4,8'd0,1,PC,1, 1,0,1,1,mk_head(2'b11,4'd4,8'd0,8'd0)), "mr_new");
    run_vec(vec(1,0,4'd0,8'd0,0,PX,1, 1,0,0,0,'0), "mr_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
